// File: rtl/bsr_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module : bsr_chain_pkg
// Brief  : Shared sizing helpers for the boundary-scan register chain.
//          Chain layout (tdi -> tdo): input cells, output cells, OE cell.
//          Provides the chain-length function and cell-index helpers used by
//          the top level to place each cell.
// Rev    : 1.0  initial release
// ============================================================================
package bsr_chain_pkg;

  localparam int unsigned DEF_NUM_IN  = 3;
  localparam int unsigned DEF_NUM_OUT = 2;

  // Total number of cells: one per input pin, one per output pin, plus OE.
  function automatic int unsigned bsr_len(input int unsigned num_in,
                                          input int unsigned num_out);
    return num_in + num_out + 1;
  endfunction

  // Index of the first output cell in the chain.
  function automatic int unsigned bsr_out_base(input int unsigned num_in);
    return num_in;
  endfunction

  // Index of the output-enable cell (last cell, nearest tdo).
  function automatic int unsigned bsr_oe_idx(input int unsigned num_in,
                                             input int unsigned num_out);
    return num_in + num_out;
  endfunction

endpackage : bsr_chain_pkg
`default_nettype wire

// File: rtl/bsr_chain_if.sv
`default_nettype none
// ============================================================================
// Module : bsr_chain_if
// Brief  : TAP-side connection to the boundary-scan chain.
//          capture_dr/shift_dr/update_dr : TAP state strobes for this chain
//          extest/intest                 : decoded instruction mode bits
//          tdi / tdo                     : serial data in / out
//          master : TAP controller side   slave : boundary-scan chain side
// Rev    : 1.0  initial release
// ============================================================================
interface bsr_chain_if;

  logic capture_dr;
  logic shift_dr;
  logic update_dr;
  logic extest;
  logic intest;
  logic tdi;
  logic tdo;

  modport master (
    output capture_dr,
    output shift_dr,
    output update_dr,
    output extest,
    output intest,
    output tdi,
    input  tdo
  );

  modport slave (
    input  capture_dr,
    input  shift_dr,
    input  update_dr,
    input  extest,
    input  intest,
    input  tdi,
    output tdo
  );

endinterface : bsr_chain_if
`default_nettype wire

// File: rtl/bsr_chain_cell.sv
`default_nettype none
// ============================================================================
// Module : bsr_chain_cell
// Brief  : One boundary-scan cell: capture/shift flop, update flop and the
//          mode mux selecting between the functional path and the update
//          flop.
// Ports  : clk_i      test clock (rising edge)
//          rst_n_i    async active-low reset
//          capture_i  load shift flop from pi_i (wins over shift_i)
//          shift_i    load shift flop from si_i
//          update_i   copy shift flop into update flop
//          mode_i     1: po_o driven by update flop, 0: po_o = pi_i
//          pi_i       parallel (functional) input
//          si_i       serial input from the previous cell / tdi
//          so_o       serial output (shift flop)
//          po_o       parallel output
// Rev    : 1.0  initial release
// ============================================================================
module bsr_chain_cell (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic capture_i,
  input  logic shift_i,
  input  logic update_i,
  input  logic mode_i,
  input  logic pi_i,
  input  logic si_i,
  output logic so_o,
  output logic po_o
);

  logic shift_q, shift_d;
  logic upd_q,   upd_d;

  // Capture has priority so an overlapping shift strobe cannot corrupt the
  // freshly sampled pin/core value.
  always_comb begin
    shift_d = shift_q;
    if (capture_i) begin
      shift_d = pi_i;
    end else if (shift_i) begin
      shift_d = si_i;
    end
  end

  // Update takes the pre-edge shift value, independent of capture/shift.
  always_comb begin
    upd_d = upd_q;
    if (update_i) begin
      upd_d = shift_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shift_q <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      upd_q   <= upd_d;
    end
  end

  assign so_o = shift_q;
  assign po_o = mode_i ? upd_q : pi_i;

endmodule : bsr_chain_cell
`default_nettype wire

// File: rtl/bsr_chain.sv
`default_nettype none
// ============================================================================
// Module : bsr_chain
// Brief  : Parametrised boundary-scan register between chip pins and core.
//          NUM_IN input cells, NUM_OUT output cells, one OE control cell.
//          Supports SAMPLE/PRELOAD, EXTEST and INTEST.
// Ports  : tck_i       test clock, all state on rising edge
//          trst_n_i    async active-low reset
//          tap_if      TAP strobes, mode bits, tdi/tdo (slave modport)
//          sys_in_i    values from input pins
//          core_in_o   values to core      (intest overrides with update)
//          core_out_i  values from core
//          core_oe_i   output enable from core
//          sys_out_o   values to output pins (extest overrides with update)
//          sys_oe_o    output enable to pins (extest overrides with update)
// Rev    : 1.0  initial release
// ============================================================================
module bsr_chain
  import bsr_chain_pkg::*;
#(
  parameter int unsigned NUM_IN  = DEF_NUM_IN,
  parameter int unsigned NUM_OUT = DEF_NUM_OUT
) (
  input  logic               tck_i,
  input  logic               trst_n_i,
  bsr_chain_if.slave         tap_if,
  input  logic [NUM_IN-1:0]  sys_in_i,
  output logic [NUM_IN-1:0]  core_in_o,
  input  logic [NUM_OUT-1:0] core_out_i,
  input  logic               core_oe_i,
  output logic [NUM_OUT-1:0] sys_out_o,
  output logic               sys_oe_o
);

  localparam int unsigned LEN      = bsr_len(NUM_IN, NUM_OUT);
  localparam int unsigned OUT_BASE = bsr_out_base(NUM_IN);
  localparam int unsigned OE_IDX   = bsr_oe_idx(NUM_IN, NUM_OUT);

  logic [LEN-1:0] cell_pi;    // functional value each cell captures
  logic [LEN-1:0] cell_mode;  // per-cell override select
  logic [LEN-1:0] cell_si;    // serial input of each cell
  logic [LEN-1:0] cell_so;    // shift flop of each cell
  logic [LEN-1:0] cell_po;    // parallel output of each cell

  // Cell order tdi -> tdo: inputs, outputs, OE.
  assign cell_pi = {core_oe_i, core_out_i, sys_in_i};
  assign cell_si = {cell_so[LEN-2:0], tap_if.tdi};

  generate
    for (genvar i = 0; i < LEN; i++) begin : g_cell
      if (i < OUT_BASE) begin : g_in_mode
        assign cell_mode[i] = tap_if.intest;
      end else begin : g_out_mode
        assign cell_mode[i] = tap_if.extest;
      end

      bsr_chain_cell u_cell (
        .clk_i     (tck_i),
        .rst_n_i   (trst_n_i),
        .capture_i (tap_if.capture_dr),
        .shift_i   (tap_if.shift_dr),
        .update_i  (tap_if.update_dr),
        .mode_i    (cell_mode[i]),
        .pi_i      (cell_pi[i]),
        .si_i      (cell_si[i]),
        .so_o      (cell_so[i]),
        .po_o      (cell_po[i])
      );
    end
  endgenerate

  assign core_in_o   = cell_po[OUT_BASE-1:0];
  assign sys_out_o   = cell_po[OE_IDX-1:OUT_BASE];
  assign sys_oe_o    = cell_po[OE_IDX];
  assign tap_if.tdo  = cell_so[LEN-1];

endmodule : bsr_chain
`default_nettype wire

// File: tb/tb_bsr_chain.sv
`default_nettype none
// ============================================================================
// Module : tb_bsr_chain
// Brief  : Directed self-checking bench for bsr_chain (NUM_IN=3, NUM_OUT=2).
// Rev    : 1.0  initial release
// ============================================================================
module tb_bsr_chain;

  logic       tck = 1'b0;
  logic       trst_n;
  logic [2:0] sys_in;
  logic [2:0] core_in;
  logic [1:0] core_out;
  logic [1:0] sys_out;
  logic       core_oe;
  logic       sys_oe;
  logic [5:0] w;

  int n_tests = 0;
  int n_fail  = 0;

  bsr_chain_if tap_if ();

  bsr_chain #(
    .NUM_IN  (3),
    .NUM_OUT (2)
  ) dut (
    .tck_i      (tck),
    .trst_n_i   (trst_n),
    .tap_if     (tap_if),
    .sys_in_i   (sys_in),
    .core_in_o  (core_in),
    .core_out_i (core_out),
    .core_oe_i  (core_oe),
    .sys_out_o  (sys_out),
    .sys_oe_o   (sys_oe)
  );

  always #5 tck = ~tck;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge tck);
    #1;
  endtask

  // Shift v in MSB first (ends up as shift[5:0] = v); out collects the bits
  // seen on tdo, first one in out[5].
  task automatic shift_word(input logic [5:0] v, output logic [5:0] out);
    tap_if.shift_dr = 1'b1;
    for (int i = 5; i >= 0; i--) begin
      out[i]     = tap_if.tdo;
      tap_if.tdi = v[i];
      step();
    end
    tap_if.shift_dr = 1'b0;
    tap_if.tdi      = 1'b0;
  endtask

  task automatic do_update();
    tap_if.update_dr = 1'b1;
    step();
    tap_if.update_dr = 1'b0;
  endtask

  task automatic do_capture();
    tap_if.capture_dr = 1'b1;
    step();
    tap_if.capture_dr = 1'b0;
  endtask

  initial begin
    tap_if.capture_dr = 1'b0;
    tap_if.shift_dr   = 1'b0;
    tap_if.update_dr  = 1'b0;
    tap_if.extest     = 1'b0;
    tap_if.intest     = 1'b0;
    tap_if.tdi        = 1'b0;
    sys_in   = 3'b000;
    core_out = 2'b00;
    core_oe  = 1'b0;
    trst_n   = 1'b0;
    step();
    step();
    trst_n = 1'b1;
    step();
    check("init_tdo", {31'd0, tap_if.tdo}, 32'd0);

    // ---- 1: reset asserted mid-shift after loading all ones ----
    shift_word(6'b111111, w);
    do_update();
    tap_if.shift_dr = 1'b1;
    tap_if.tdi      = 1'b1;
    step();
    step();
    step();
    check("pre_reset_tdo", {31'd0, tap_if.tdo}, 32'd1);
    #2;
    trst_n = 1'b0;
    #1;
    check("reset_tdo", {31'd0, tap_if.tdo}, 32'd0);
    sys_in   = 3'b010;
    core_out = 2'b01;
    core_oe  = 1'b1;
    #1;
    check("reset_core_in", {29'd0, core_in}, 32'h2);
    check("reset_sys_out", {30'd0, sys_out}, 32'h1);
    check("reset_sys_oe", {31'd0, sys_oe}, 32'd1);
    tap_if.extest = 1'b1;
    tap_if.intest = 1'b1;
    #1;
    check("reset_upd_out", {30'd0, sys_out}, 32'd0);
    check("reset_upd_oe", {31'd0, sys_oe}, 32'd0);
    check("reset_upd_in", {29'd0, core_in}, 32'd0);
    tap_if.extest   = 1'b0;
    tap_if.intest   = 1'b0;
    tap_if.shift_dr = 1'b0;
    tap_if.tdi      = 1'b0;
    step();
    trst_n = 1'b1;
    step();
    shift_word(6'b000000, w);
    check("reset_shift_cleared", {26'd0, w}, 32'd0);

    // ---- 2: SAMPLE ----
    sys_in   = 3'b101;
    core_out = 2'b10;
    core_oe  = 1'b1;
    do_capture();
    check("sample_tdo_at_capture", {31'd0, tap_if.tdo}, 32'd1);
    shift_word(6'b000000, w);
    check("sample_stream", {26'd0, w}, 32'h35);  // 1,1,0,1,0,1

    // ---- 3: PRELOAD + EXTEST ----
    shift_word(6'b101000, w);
    do_update();
    tap_if.extest = 1'b1;
    core_out = 2'b10;
    core_oe  = 1'b0;
    #1;
    check("extest_sys_out", {30'd0, sys_out}, 32'h1);
    check("extest_sys_oe", {31'd0, sys_oe}, 32'd1);
    core_out = 2'b11;
    #1;
    check("extest_sys_out_ignore_core", {30'd0, sys_out}, 32'h1);
    check("extest_core_in_transparent", {29'd0, core_in}, 32'h5);

    // ---- 4: INTEST ----
    tap_if.extest = 1'b0;
    shift_word(6'b000110, w);
    do_update();
    tap_if.intest = 1'b1;
    sys_in = 3'b000;
    #1;
    check("intest_core_in_a", {29'd0, core_in}, 32'h6);
    sys_in = 3'b111;
    #1;
    check("intest_core_in_b", {29'd0, core_in}, 32'h6);
    check("intest_sys_out_transparent", {30'd0, sys_out}, 32'h3);
    tap_if.intest = 1'b0;
    #1;
    check("intest_off_core_in", {29'd0, core_in}, 32'h7);

    // ---- 5: update stage holds during shift ----
    shift_word(6'b100000, w);
    do_update();
    tap_if.extest = 1'b1;
    #1;
    check("hold_sys_out_a", {30'd0, sys_out}, 32'h0);
    check("hold_sys_oe_a", {31'd0, sys_oe}, 32'd1);
    shift_word(6'b011111, w);
    check("hold_sys_out_b", {30'd0, sys_out}, 32'h0);
    check("hold_sys_oe_b", {31'd0, sys_oe}, 32'd1);
    // Update overlapping a shift takes the pre-edge value 011111.
    tap_if.intest    = 1'b1;
    tap_if.tdi       = 1'b0;
    tap_if.shift_dr  = 1'b1;
    tap_if.update_dr = 1'b1;
    step();
    tap_if.shift_dr  = 1'b0;
    tap_if.update_dr = 1'b0;
    check("ovl_upd_sys_out", {30'd0, sys_out}, 32'h3);
    check("ovl_upd_sys_oe", {31'd0, sys_oe}, 32'd0);
    check("ovl_upd_core_in", {29'd0, core_in}, 32'h7);
    // Shift stage now holds 111110.
    do_update();
    check("post_upd_sys_oe", {31'd0, sys_oe}, 32'd1);
    check("post_upd_core_in", {29'd0, core_in}, 32'h6);

    // ---- 6: capture wins over shift on the same edge ----
    tap_if.extest     = 1'b0;
    tap_if.intest     = 1'b0;
    sys_in            = 3'b011;
    core_out          = 2'b01;
    core_oe           = 1'b0;
    tap_if.tdi        = 1'b1;
    tap_if.capture_dr = 1'b1;
    tap_if.shift_dr   = 1'b1;
    step();
    tap_if.capture_dr = 1'b0;
    tap_if.shift_dr   = 1'b0;
    tap_if.tdi        = 1'b0;
    check("ovl_cap_tdo", {31'd0, tap_if.tdo}, 32'd0);
    shift_word(6'b000000, w);
    check("ovl_cap_in_cells", {29'd0, w[2:0]}, 32'h3);
    check("ovl_cap_stream", {26'd0, w}, 32'h0B);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_bsr_chain
`default_nettype wire
